// File: rtl/adc_writer_pkg.sv
// adc_writer_pkg: shared types, record layout and helpers for the ADC sample RAM writer
package adc_writer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int CHAN_LSB = 12;
  localparam int CHAN_W = 3;
  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW = 4'b0011;
  function automatic logic [15:0] make_half(input logic [CHAN_W-1:0] chan, input logic [CHAN_LSB-1:0] code);
    return {1'b0, chan, code};
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/adc_word_fifo.sv
// adc_word_fifo: small synchronous FIFO of {byteenable, data} entries, push allowed when full if popping
module adc_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rp[AW-1:0]];
  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  // Pointers; reset invalidates every entry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/adc_sample_ram_writer.sv
// adc_sample_ram_writer: packs ADC samples into 32-bit words and writes them into a circular RAM window
module adc_sample_ram_writer
  import adc_writer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int BASE_WORD = 1024,
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [2:0]        sample_chan,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              irq_clear,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       wrap_count,
  output logic [15:0]       overrun_count,
  output logic              half_irq,
  output logic              full_irq
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(BASE_WORD + DEPTH_WORDS/2 - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_WORD + DEPTH_WORDS - 1);
  state_t state;
  logic have_half, pend_valid, fifo_full, fifo_empty, done, hs, drained, start;
  logic [15:0] half_lo, rec;
  logic [35:0] pend, head;
  assign rec = make_half(sample_chan, CHAN_LSB'(sample_data));
  assign sample_ready = state == RUN;
  assign hs = sample_valid && sample_ready;
  assign busy = state != IDLE;
  assign start = state == IDLE && ctrl_start;
  assign m_write = !fifo_empty;
  assign m_chipselect = m_write;
  assign m_address = wr_ptr;
  assign m_writedata = m_write ? head[31:0] : '0;
  assign m_byteenable = m_write ? head[35:32] : '0;
  assign done = m_write && !m_waitrequest;
  assign drained = fifo_empty && !pend_valid && !have_half;
  adc_word_fifo #(.DEPTH(FIFO_DEPTH), .W(36)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(pend_valid),
    .pop(done),
    .din(pend),
    .full(fifo_full),
    .empty(fifo_empty),
    .head(head)
  );
  // Capture control: start opens the window, stop drains until every queued word is written
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state == IDLE ? (ctrl_start ? RUN : IDLE) :
                  state == RUN ? (ctrl_stop ? DRAIN : RUN) : (drained ? IDLE : DRAIN);
  // Pair samples into words one cycle ahead of the FIFO; a lone half is flushed on drain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      have_half <= 1'b0;
      half_lo <= '0;
      pend_valid <= 1'b0;
      pend <= '0;
    end else if (state == IDLE) begin
      have_half <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= have_half && (hs || state == DRAIN);
      pend <= state == DRAIN ? {BE_LOW, 16'h0000, half_lo} : {BE_FULL, rec, half_lo};
      have_half <= hs ? !have_half : have_half && state != DRAIN;
      if (hs && !have_half) half_lo <= rec;
    end
  // Window pointer, wrap/overrun statistics and sticky interrupts (a set beats a clear)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      wrap_count <= '0;
      overrun_count <= '0;
      half_irq <= 1'b0;
      full_irq <= 1'b0;
    end else begin
      if (start) begin
        wr_ptr <= BASE;
        wrap_count <= '0;
        overrun_count <= '0;
      end else begin
        if (done) wr_ptr <= wr_ptr == LAST ? BASE : wr_ptr + ADDR_W'(1);
        if (done && wr_ptr == LAST) wrap_count <= sat_inc(wrap_count);
        if (pend_valid && fifo_full && !done) overrun_count <= sat_inc(overrun_count);
      end
      half_irq <= (done && wr_ptr == HALF) || (half_irq && !irq_clear);
      full_irq <= (done && wr_ptr == LAST) || (full_irq && !irq_clear);
    end
endmodule

// File: tb/tb_adc_sample_ram_writer.sv
// tb_adc_sample_ram_writer: scoreboard bench with a transaction-level model of the capture window
module tb_adc_sample_ram_writer;
  localparam int ADDR_W = 11, BASE = 1024, DEPTH = 4, FD = 4, SW = 12;
  localparam int HALF = BASE + DEPTH/2 - 1, LAST = BASE + DEPTH - 1;
  typedef struct {int addr; logic [3:0] be; logic [31:0] data;} wr_t;
  logic clk = 0, reset_n = 0, sample_valid = 0, ctrl_start = 0, ctrl_stop = 0;
  logic irq_pulse = 0, arm_clear = 0, m_waitrequest = 0, irq_clear;
  logic [SW-1:0] sample_data = '0;
  logic [2:0] sample_chan = '0;
  logic sample_ready, m_chipselect, m_write, busy, half_irq, full_irq;
  logic [ADDR_W-1:0] m_address, wr_ptr;
  logic [3:0] m_byteenable;
  logic [31:0] m_writedata;
  logic [15:0] wrap_count, overrun_count;
  wr_t exp_q[$];
  int m_ptr = 0, m_wrap = 0, m_over = 0, hold_cnt = 0, stall_mode = 0, vec = 0, miscmp = 0;
  bit m_half = 0, m_full = 0, m_have = 0, hold_model = 0;
  logic [15:0] m_lo = '0;

  assign irq_clear = irq_pulse | (arm_clear && m_write && !m_waitrequest && m_address == ADDR_W'(LAST));

  adc_sample_ram_writer #(.ADDR_W(ADDR_W), .BASE_WORD(BASE), .DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD), .SAMPLE_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_chan(sample_chan), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .irq_clear(irq_clear), .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .busy(busy),
    .wr_ptr(wr_ptr), .wrap_count(wrap_count), .overrun_count(overrun_count),
    .half_irq(half_irq), .full_irq(full_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: every kept word takes the next window slot in order; irqs and wraps follow the slot it lands in
  function automatic void model_word(input logic [31:0] d, input logic [3:0] be);
    if (hold_model && hold_cnt >= FD) m_over = m_over == 65535 ? m_over : m_over + 1;
    else begin
      hold_cnt++;
      exp_q.push_back('{m_ptr, be, d});
      if (m_ptr == HALF) m_half = 1;
      if (m_ptr == LAST) begin
        m_full = 1;
        m_wrap = m_wrap == 65535 ? m_wrap : m_wrap + 1;
        if (arm_clear) m_half = 0;
        m_ptr = BASE;
      end else m_ptr++;
    end
  endfunction

  function automatic void model_sample(input logic [2:0] ch, input logic [11:0] d);
    logic [15:0] h;
    h = {1'b0, ch, d};
    if (m_have) begin
      model_word({h, m_lo}, 4'b1111);
      m_have = 0;
    end else begin
      m_lo = h;
      m_have = 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap();
    ctrl_start = 1;
    step();
    ctrl_start = 0;
    m_ptr = BASE; m_wrap = 0; m_over = 0; hold_cnt = 0; m_have = 0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [11:0] d);
    check("ready_in_run", sample_ready, 1);
    sample_valid = 1; sample_chan = ch; sample_data = d;
    step();
    sample_valid = 0;
    model_sample(ch, d);
  endtask

  task automatic clear_irqs();
    irq_pulse = 1;
    step();
    irq_pulse = 0;
    m_half = 0; m_full = 0;
  endtask

  task automatic stop_cap();
    ctrl_stop = 1;
    step();
    ctrl_stop = 0;
    check("ready_in_drain", sample_ready, 0);
    if (m_have) begin
      model_word({16'h0000, m_lo}, 4'b0011);
      m_have = 0;
    end
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("drain_done", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    check("wr_ptr", wr_ptr, m_ptr);
    check("wrap_count", wrap_count, m_wrap);
    check("overrun_count", overrun_count, m_over);
    check("half_irq", half_irq, m_half);
    check("full_irq", full_irq, m_full);
    check("idle_no_write", m_write, 0);
    step();
  endtask

  // Interconnect stall generator
  initial forever begin
    @(posedge clk);
    #1;
    m_waitrequest = stall_mode == 2 ? 1'b1 : stall_mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // Monitor: stalled requests must hold still; each completion pops and matches the next expected write
  initial begin
    wr_t e;
    logic held;
    logic [ADDR_W-1:0] ha;
    logic [31:0] hd;
    logic [3:0] hb;
    held = 0; ha = '0; hd = '0; hb = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) held = 0;
      else begin
        if (held && m_write) begin
          check("stall_addr", m_address, ha);
          check("stall_data", m_writedata, hd);
          check("stall_be", m_byteenable, hb);
        end
        if (m_write && !m_waitrequest) begin
          check("chipselect", m_chipselect, 1);
          if (exp_q.size() == 0) begin
            vec++;
            miscmp++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", m_address, m_writedata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", m_address, e.addr);
            check("wr_data", m_writedata, e.data);
            check("wr_be", m_byteenable, e.be);
          end
          held = 0;
        end else begin
          held = m_write;
          ha = m_address; hd = m_writedata; hb = m_byteenable;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_write", m_write, 0);
    check("rst_ready", sample_ready, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_irqs", {half_irq, full_irq}, 0);
    @(negedge clk);
    reset_n = 1;
    step();
    // Directed packing and first-write latency
    start_cap();
    send(3'd2, 12'h001);
    send(3'd2, 12'h002);
    @(negedge clk);
    check("lat_cycle1", m_write, 0);
    @(negedge clk);
    check("lat_cycle2", m_write, 1);
    step();
    send(3'd2, 12'h003);
    send(3'd2, 12'h004);
    stop_cap();
    check("t1_wr_ptr", wr_ptr, 1026);
    // Long stall on the first write
    stall_mode = 2;
    step();
    start_cap();
    for (int i = 0; i < 4; i++) send(3'($urandom), 12'($urandom));
    for (int i = 0; i < 20 && !m_write; i++) step();
    check("stall_write_up", m_write, 1);
    repeat (5) @(negedge clk);
    stall_mode = 0;
    step();
    stop_cap();
    // Overrun with the master stalled for the whole burst
    clear_irqs();
    hold_model = 1;
    stall_mode = 2;
    step();
    start_cap();
    for (int i = 0; i < 12; i++) send(3'($urandom), 12'($urandom));
    repeat (3) step();
    check("overrun_live", overrun_count, 2);
    hold_model = 0;
    stall_mode = 0;
    stop_cap();
    // Window wrap, clear colliding with set, and a start pulse while busy
    clear_irqs();
    arm_clear = 1;
    start_cap();
    for (int i = 0; i < 10; i++) begin
      send(3'($urandom), 12'($urandom));
      if (i == 4) begin
        ctrl_start = 1;
        step();
        ctrl_start = 0;
      end
    end
    stop_cap();
    arm_clear = 0;
    check("wrap_once", wrap_count, 1);
    check("full_set_wins", full_irq, 1);
    clear_irqs();
    check("irq_cleared", {half_irq, full_irq}, 0);
    // Odd sample count leaves a tail word
    start_cap();
    for (int i = 0; i < 3; i++) send(3'($urandom), 12'($urandom));
    stop_cap();
    // Randomized captures under random stalls
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) clear_irqs();
      stall_mode = 1;
      start_cap();
      for (int i = 0, k = $urandom_range(1, 8); i < k; i++) begin
        send(3'($urandom), 12'($urandom));
        repeat ($urandom_range(0, 2)) step();
      end
      stop_cap();
      stall_mode = 0;
    end
    // Reset while a write is stalled
    stall_mode = 2;
    step();
    start_cap();
    send(3'd5, 12'h0AB);
    send(3'd6, 12'h0CD);
    for (int i = 0; i < 20 && !m_write; i++) step();
    check("pre_reset_write", m_write, 1);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("arst_write", m_write, 0);
    check("arst_chipselect", m_chipselect, 0);
    check("arst_bus", {m_address, m_writedata, m_byteenable}, 0);
    check("arst_busy", busy, 0);
    check("arst_status", {wr_ptr, wrap_count, overrun_count, half_irq, full_irq}, 0);
    exp_q.delete();
    m_ptr = 0; m_wrap = 0; m_over = 0; m_half = 0; m_full = 0; m_have = 0;
    stall_mode = 0;
    @(negedge clk);
    reset_n = 1;
    repeat (10) step();
    check("post_reset_idle", m_write, 0);
    check("post_reset_ptr", wr_ptr, 0);
    start_cap();
    send(3'd1, 12'h123);
    send(3'd1, 12'h456);
    stop_cap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule

// File: doc/adc_sample_ram_writer.md
Name: adc_sample_ram_writer

Overview:
- Upstream stage of the 2048x32 on-chip sample RAM in nios_system.
- Accepts ADC samples on a valid/ready stream and packs two 16-bit sample records into each 32-bit word.
- Writes the words into a circular window of the RAM through an Avalon-MM write master.
- The Nios reads captured data from the same RAM; this block reports progress through status outputs and sticky half/full interrupt flags.

Parameters:
- ADDR_W, 11, word-address width; matches the RAM address port.
- BASE_WORD, 1024, first word of the circular window.
- DEPTH_WORDS, 1024, window size in words; must be an even value ≥4 and BASE_WORD+DEPTH_WORDS ≤ 2^ADDR_W.
- FIFO_DEPTH, 4, word FIFO depth; power of two.
- SAMPLE_W, 12, ADC sample width; must be ≤12.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample present.
- sample_ready  out  1  block accepts a sample this cycle.
- sample_data  in  SAMPLE_W  ADC code.
- sample_chan  in  3  ADC channel number.
- ctrl_start  in  1  single-cycle pulse; begins capture.
- ctrl_stop  in  1  single-cycle pulse; ends capture.
- irq_clear  in  1  single-cycle pulse; clears half_irq and full_irq.
- m_address  out  ADDR_W  word address.
- m_byteenable  out  4  byte lanes.
- m_chipselect  out  1  equals m_write.
- m_write  out  1  write request.
- m_writedata  out  32  packed word.
- m_waitrequest  in  1  interconnect stall.
- busy  out  1  state != IDLE.
- wr_ptr  out  ADDR_W  next word address to be written.
- wrap_count  out  16  number of window wraps; saturating.
- overrun_count  out  16  number of dropped words; saturating.
- half_irq  out  1  sticky; first half of the window written.
- full_irq  out  1  sticky; last word of the window written.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. An assertion of reset_n mid-transfer aborts that transfer immediately, with no completion.
- Record format: half = {1'b0, sample_chan, zero-extended sample_data} (16 bits).
- Word format: {second_half, first_half}. The first accepted sample goes in bits [15:0].
- States:
  - IDLE: ctrl_start → RUN. On entry to RUN: wr_ptr = BASE_WORD, both counts cleared, packer and FIFO emptied, irqs unchanged. ctrl_stop is ignored.
  - RUN: sample_ready = 1. A handshake occurs when valid & ready.
    - The first sample is latched in the packer.
    - The second sample forms a word that is pushed to the FIFO on the next clock, with byteenable 4'b1111.
    - If the FIFO is full at push time, the word is dropped and overrun_count increments.
    - ctrl_stop → DRAIN.
  - DRAIN: sample_ready = 0.
    - A pending half-word is pushed with the upper half zero and byteenable 4'b0011; if the FIFO is full, it is counted as an overrun.
    - → IDLE once the FIFO is empty and no write is outstanding.
  - ctrl_start while busy is ignored.
- Master rules:
  - m_write rises when the FIFO is non-empty.
  - address, data and byteenable are held stable while m_waitrequest = 1.
  - A transfer completes on a cycle with m_write & !m_waitrequest. On completion the FIFO head pops, and m_write stays high back-to-back if another entry is present.
  - m_address = wr_ptr.
- Latency: second sample accepted in cycle N → FIFO push at edge N+1 → m_write high in cycle N+2 (empty FIFO, no stall).
- Pointer and irq updates, per completed write:
  - wr_ptr increments.
  - Write at BASE_WORD+DEPTH_WORDS/2-1 → half_irq = 1.
  - Write at BASE_WORD+DEPTH_WORDS-1 → wr_ptr = BASE_WORD, wrap_count +1 (saturates at 0xFFFF), full_irq = 1.
- Simultaneous events:
  - irq set and irq_clear in the same cycle: set wins.
  - FIFO push and pop in the same cycle: occupancy unchanged, so a push is allowed even when full if a pop occurs that cycle.
  - overrun_count saturates at 0xFFFF.

Decomposition:
- Package adc_writer_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - Record field positions: CHAN_LSB = 12, CHAN_W = 3.
  - BE_FULL = 4'b1111, BE_LOW = 4'b0011.
- Sub-module adc_word_fifo: synchronous FIFO of {byteenable, data}, 36 bits wide, FIFO_DEPTH entries.
  - Ports: push, pop, full, empty, head.
  - Reset: async active-low; all entries are invalidated.

Test Plan:
- start, 4 samples on chan 2 (0x001, 0x002, 0x003, 0x004), no stall → writes 0x20022001 @1024 then 0x20042003 @1025, BE 4'b1111; wr_ptr = 1026.
- m_waitrequest held high 5 cycles on the first write → address/data/BE stable throughout; exactly one completion; no overrun for ≤ 2*FIFO_DEPTH samples.
- waitrequest held high while 12 samples stream in (6 words, FIFO_DEPTH 4) → 4 words written in order, overrun_count = 2.
- DEPTH_WORDS = 4, 10 samples → half_irq after the write @1025; wrap after @1027; word 5 lands @1024; wrap_count = 1, full_irq = 1; irq_clear on the same cycle as the set → flag stays 1.
- 3 samples then ctrl_stop → tail word written with upper half 0x0000 and BE 4'b0011; busy falls after the final completion.
- reset_n low while m_write is stalled → all outputs 0 asynchronously; after release, no write occurs until ctrl_start.
